// File: rtl/mem_datos_resp.sv
// MEM-stage data-memory responder: aligned writes, fixed-latency reads with stall,
// control word forwarding to MEM/WB. Optional write bypass under MEM_WRITE_BYPASS_EN.
module mem_datos_resp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        Control,
    input  logic [31:0]       Direccion,
    input  logic [DATA_W-1:0] DatoEscr,
    output logic              Stall,
    output logic [DATA_W-1:0] DatoLeido,
    output logic              Valido,
    output logic              ErrorMem,
    output logic [9:0]        Controls3
);
    typedef enum logic {IDLE, READ} state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    state_t            state;
    logic [3:0]        counter;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              leer, escr, misal, accept, mem_we, hit;
    logic [ADDR_W-1:0] idx;
    logic              unused_bits;

    assign leer        = Control[4];
    assign escr        = Control[3];
    assign idx         = Direccion[ADDR_W+1:2];
    assign misal       = |Direccion[1:0];
    // Valido blocks re-issue of the request still held on the inputs.
    assign accept      = (state == IDLE) && !Valido;
    assign mem_we      = reset && accept && escr && !misal;
    assign unused_bits = ^Direccion[31:ADDR_W+2];

`ifdef MEM_WRITE_BYPASS_EN
    logic              byp_vld, rd_byp;
    logic [ADDR_W-1:0] byp_idx;
    logic [DATA_W-1:0] byp_data;
    assign hit = byp_vld && (byp_idx == idx);
`else
    assign hit = 1'b0;
`endif

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= DatoEscr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= '0;
            rd_idx    <= '0;
            Stall     <= 1'b0;
            Valido    <= 1'b0;
            ErrorMem  <= 1'b0;
            DatoLeido <= '0;
            Controls3 <= '0;
`ifdef MEM_WRITE_BYPASS_EN
            byp_vld   <= 1'b0;
            rd_byp    <= 1'b0;
            byp_idx   <= '0;
            byp_data  <= '0;
`endif
        end else begin
            Valido   <= 1'b0;
            ErrorMem <= 1'b0;
            case (state)
                IDLE: begin
                    Controls3 <= Control;
                    if (accept) begin
                        if ((leer || escr) && misal) begin
                            ErrorMem <= 1'b1;
                        end else if (escr) begin
                            ErrorMem <= leer;
`ifdef MEM_WRITE_BYPASS_EN
                            byp_vld  <= 1'b1;
                            byp_idx  <= idx;
                            byp_data <= DatoEscr;
`endif
                        end else if (leer) begin
                            rd_idx    <= idx;
                            counter   <= hit ? 4'd0 : LAT_M1;
                            state     <= READ;
                            Stall     <= 1'b1;
                            Controls3 <= Controls3;
`ifdef MEM_WRITE_BYPASS_EN
                            rd_byp    <= hit;
`endif
                        end
                    end
                end
                READ: begin
                    if (counter == 4'd0) begin
`ifdef MEM_WRITE_BYPASS_EN
                        DatoLeido <= rd_byp ? byp_data : mem[rd_idx];
`else
                        DatoLeido <= mem[rd_idx];
`endif
                        Valido    <= 1'b1;
                        Stall     <= 1'b0;
                        state     <= IDLE;
                        Controls3 <= Control;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_datos_resp.sv
// Self-checking bench for mem_datos_resp: directed scenarios plus randomized traffic
// against an associative-array memory model.
module tb_mem_datos_resp;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    Control;
    logic [31:0]   Direccion;
    logic [DW-1:0] DatoEscr;
    logic          Stall, Valido, ErrorMem;
    logic [DW-1:0] DatoLeido;
    logic [9:0]    Controls3;

    mem_datos_resp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset), .Control(Control), .Direccion(Direccion),
        .DatoEscr(DatoEscr), .Stall(Stall), .DatoLeido(DatoLeido), .Valido(Valido),
        .ErrorMem(ErrorMem), .Controls3(Controls3)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mm [int];
    int            wq [$];
    bit            bv = 0;
    int            bidx = 0;

    function automatic int exp_lat(input int i);
`ifdef MEM_WRITE_BYPASS_EN
        if (bv && i == bidx) return 1;
`endif
        return RL;
    endfunction

    task automatic idle();
        Control = '0; Direccion = '0; DatoEscr = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d, input logic both,
                            input string nm);
        logic exp_err;
        @(negedge clk);
        Control   = {5'($urandom), both, 1'b1, 3'($urandom)};
        Direccion = a;
        DatoEscr  = d;
        exp_err   = both || (a[1:0] != 2'b00);
        @(negedge clk);
        n_checks++;
        if (ErrorMem !== exp_err) begin
            n_fail++; $display("FAIL %s err: got %0b expected %0b", nm, ErrorMem, exp_err);
        end
        n_checks++;
        if (Stall !== 1'b0) begin
            n_fail++; $display("FAIL %s stall: got %0b expected 0", nm, Stall);
        end
        n_checks++;
        if (Controls3 !== Control) begin
            n_fail++; $display("FAIL %s ctl: got %0h expected %0h", nm, Controls3, Control);
        end
        if (a[1:0] == 2'b00) begin
            mm[int'(a[AW+1:2])] = d;
            wq.push_back(int'(a[AW+1:2]));
            bv = 1; bidx = int'(a[AW+1:2]);
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (ErrorMem !== 1'b0) begin
            n_fail++; $display("FAIL %s err_pulse: got %0b expected 0", nm, ErrorMem);
        end
    endtask

    // Inputs are held until the Valido cycle, then dropped.
    task automatic do_read(input logic [31:0] a, input string nm);
        int            lat, stalls, vcnt, extra;
        logic [DW-1:0] exp;
        logic [9:0]    c;
        exp = mm[int'(a[AW+1:2])];
        lat = exp_lat(int'(a[AW+1:2]));
        @(negedge clk);
        c = {5'($urandom), 1'b1, 1'b0, 3'($urandom)};
        Control = c; Direccion = a; DatoEscr = DW'($urandom);
        stalls = 0; vcnt = 0;
        for (int i = 0; i < 40 && vcnt == 0; i++) begin
            @(negedge clk);
            if (Stall) stalls++;
            if (Valido) vcnt++;
        end
        n_checks++;
        if (vcnt != 1) begin
            n_fail++; $display("FAIL %s timeout: got %0d valid expected 1", nm, vcnt);
        end
        n_checks++;
        if (stalls != lat) begin
            n_fail++; $display("FAIL %s stall_len: got %0d expected %0d", nm, stalls, lat);
        end
        n_checks++;
        if (DatoLeido !== exp) begin
            n_fail++; $display("FAIL %s data: got %0h expected %0h", nm, DatoLeido, exp);
        end
        n_checks++;
        if (Controls3 !== c) begin
            n_fail++; $display("FAIL %s ctl: got %0h expected %0h", nm, Controls3, c);
        end
        idle();
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (Stall || Valido) extra++;
        end
        n_checks++;
        if (extra != 0 || DatoLeido !== exp) begin
            n_fail++; $display("FAIL %s reissue: got %0d extra/%0h expected 0/%0h", nm, extra, DatoLeido, exp);
        end
    endtask

    task automatic test_reset();
        int bad;
        idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({Stall, Valido, ErrorMem} !== 3'b000 || DatoLeido !== '0 || Controls3 !== '0) begin
            n_fail++; $display("FAIL reset_outs: got %0b%0b%0b/%0h/%0h expected 0", Stall, Valido, ErrorMem, DatoLeido, Controls3);
        end
        reset = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (Stall !== 1'b0 || Valido !== 1'b0 || ErrorMem !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || DatoLeido !== '0 || Controls3 !== '0) begin
            n_fail++; $display("FAIL idle_after_reset: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_write_read();
        do_write(32'h10, 32'hDEADBEEF, 1'b0, "wr10");
        do_read(32'h10, "rd10");
    endtask

    task automatic test_back_to_back();
        do_read(32'h10, "b2b_a");
        do_read(32'h10, "b2b_b");
    endtask

    task automatic test_misaligned();
        do_write(32'h13, 32'h0BADF00D, 1'b0, "wr13");
        do_read(32'h10, "rd10_after_mis");
        @(negedge clk);
        Control = 10'h010; Direccion = 32'h12;
        @(negedge clk);
        n_checks++;
        if (ErrorMem !== 1'b1 || Stall !== 1'b0) begin
            n_fail++; $display("FAIL mis_read: got err=%0b stall=%0b expected 1/0", ErrorMem, Stall);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_both();
        do_write(32'h20, 32'h12345678, 1'b1, "both20");
        do_read(32'h20, "rd20");
    endtask

    task automatic test_reset_abort();
        int bad;
        do_write(32'h44, DW'($urandom), 1'b0, "wr44");
        @(negedge clk);
        Control = 10'h010; Direccion = 32'h10;
        @(negedge clk);
        n_checks++;
        if (Stall !== 1'b1) begin
            n_fail++; $display("FAIL abort_stall1: got %0b expected 1", Stall);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (Stall !== 1'b0 || Valido !== 1'b0 || Controls3 !== '0) begin
            n_fail++; $display("FAIL abort_outs: got %0b/%0b/%0h expected 0", Stall, Valido, Controls3);
        end
        @(negedge clk);
        reset = 1'b1;
        bv = 0;
        idle();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (Valido || Stall) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL abort_no_valid: got %0d cycles expected 0", bad);
        end
        do_read(32'h10, "rd_after_abort");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [9:0]  c;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = {22'($urandom), 8'($urandom), 2'b00};
                    do_write(a, DW'($urandom), 1'($urandom), "rnd_wr");
                end
                1: begin
                    a = {30'($urandom), 2'($urandom_range(1, 3))};
                    do_write(a, DW'($urandom), 1'b0, "rnd_mis");
                end
                2: begin
                    if (wq.size() > 0) begin
                        a = {22'($urandom), 8'(wq[$urandom_range(0, wq.size() - 1)]), 2'b00};
                        do_read(a, "rnd_rd");
                    end
                end
                default: begin
                    @(negedge clk);
                    c = {5'($urandom), 2'b00, 3'($urandom)};
                    Control = c; Direccion = $urandom;
                    @(negedge clk);
                    n_checks++;
                    if (Controls3 !== c || Stall !== 1'b0) begin
                        n_fail++; $display("FAIL rnd_idle: got %0h/%0b expected %0h/0", Controls3, Stall, c);
                    end
                    idle();
                end
            endcase
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_misaligned();
        test_both();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
